// File: rtl/mem_read_a.sv
// Read-side address generator for the A operand buffer: streams each row tile
// column by column, replays it M3dN2 times, and skews bank b by b cycles (N1 >= 2).
// Build option MEM_READ_A_CHECK_EN enables configuration checking and the err flag.
module mem_read_a #(
    parameter int N1           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W       = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stall,
    input  logic [MATRIXSIZE_W-1:0]  M2,
    input  logic [MATRIXSIZE_W-1:0]  M1dN1,
    input  logic [MATRIXSIZE_W-1:0]  M3dN2,
    output logic [N1*ADDR_W-1:0]     rd_addr_A,
    output logic [N1-1:0]            rd_en_A,
    output logic                     tile_last_A,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    // state  | meaning
    // IDLE   | waiting for start
    // STREAM | issuing bank-0 reads, one per non-stalled cycle
    // DRAIN  | flushing the skew line for N1-1 non-stalled cycles
    // DONE   | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    localparam logic [MATRIXSIZE_W-1:0] ONE = MATRIXSIZE_W'(1);

    state_t                  state_q, state_d;
    logic [MATRIXSIZE_W-1:0] m2_q, m1_q, m3_q;
    logic [MATRIXSIZE_W-1:0] k_q, q_q, p_q, base_q, drain_q;
    logic                    sk_en_q   [1:N1-1];
    logic [ADDR_W-1:0]       sk_addr_q [1:N1-1];
    logic                    bad_q;
    logic                    issue, last_k, last_q, last_p, accept;
    logic [ADDR_W-1:0]       addr0;

`ifdef MEM_READ_A_CHECK_EN
    localparam logic [2*MATRIXSIZE_W-1:0] ADDR_SPAN =
        {{(2*MATRIXSIZE_W-1){1'b0}}, 1'b1} << ADDR_W;
    logic                      cfg_bad, err_q;
    logic [2*MATRIXSIZE_W-1:0] area;

    always_comb begin
        area    = {{MATRIXSIZE_W{1'b0}}, M1dN1} * {{MATRIXSIZE_W{1'b0}}, M2};
        cfg_bad = (M2 == '0) || (M1dN1 == '0) || (M3dN2 == '0) || (area > ADDR_SPAN);
    end

    // A rejected configuration still passes through STREAM for one silent cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else if (accept) begin
            bad_q <= cfg_bad;
            err_q <= cfg_bad;
        end
    end
    assign err = err_q;
`else
    assign bad_q = 1'b0;
    assign err   = 1'b0;
`endif

    assign accept = (state_q == IDLE) && start;
    assign issue  = (state_q == STREAM) && !stall && !bad_q;
    assign last_k = (k_q == m2_q - ONE);
    assign last_q = (q_q == m3_q - ONE);
    assign last_p = (p_q == m1_q - ONE);
    // Truncating before the add gives the same low bits as adding at full width.
    assign addr0  = base_q[ADDR_W-1:0] + k_q[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM: begin
                if (bad_q)                               state_d = DONE;
                else if (issue && last_k && last_q && last_p) state_d = DRAIN;
            end
            DRAIN:   if (!stall && drain_q == MATRIXSIZE_W'(N1 - 2)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2_q    <= '0;
            m1_q    <= '0;
            m3_q    <= '0;
            k_q     <= '0;
            q_q     <= '0;
            p_q     <= '0;
            base_q  <= '0;
            drain_q <= '0;
            for (int b = 1; b < N1; b++) begin
                sk_en_q[b]   <= 1'b0;
                sk_addr_q[b] <= '0;
            end
        end else begin
            if (accept) begin
                m2_q    <= M2;
                m1_q    <= M1dN1;
                m3_q    <= M3dN2;
                k_q     <= '0;
                q_q     <= '0;
                p_q     <= '0;
                base_q  <= '0;
                drain_q <= '0;
            end else if (issue) begin
                if (!last_k) begin
                    k_q <= k_q + ONE;
                end else begin
                    k_q <= '0;
                    if (!last_q) begin
                        q_q <= q_q + ONE;
                    end else begin
                        q_q <= '0;
                        if (last_p) begin
                            p_q    <= '0;
                            base_q <= '0;
                        end else begin
                            p_q    <= p_q + ONE;
                            base_q <= base_q + m2_q;
                        end
                    end
                end
            end else if (state_q == DRAIN && !stall) begin
                drain_q <= drain_q + ONE;
            end
            if (!stall) begin
                sk_en_q[1]   <= issue;
                sk_addr_q[1] <= addr0;
                for (int b = 2; b < N1; b++) begin
                    sk_en_q[b]   <= sk_en_q[b-1];
                    sk_addr_q[b] <= sk_addr_q[b-1];
                end
            end
        end
    end

    always_comb begin
        rd_en_A              = '0;
        rd_addr_A            = '0;
        rd_en_A[0]           = issue;
        rd_addr_A[ADDR_W-1:0] = addr0;
        for (int b = 1; b < N1; b++) begin
            rd_en_A[b]                   = sk_en_q[b] & ~stall;
            rd_addr_A[b*ADDR_W +: ADDR_W] = sk_addr_q[b];
        end
        tile_last_A = issue && last_k;
        busy        = (state_q == STREAM) || (state_q == DRAIN);
        done        = (state_q == DONE);
    end

endmodule
